audio_source_arbiter: RTL
=========================

# audio_source_arbiter

Shares the speaker output path between two sample producers: a music source (port 0) and an alert/beep source (port 1). At each I2S frame boundary, taken from the `audio_ws` line driven by `speaker_control`, it selects one source. It consumes one stereo sample from that source through a valid/ready handshake and presents the sample as a registered, frame-stable word on `audio_in_left`/`audio_in_right` of `speaker_control`. It sits directly between the sound generators and `speaker_control`.

## Interface

- `SYNC_STAGES`, 2, flip-flop stages used to synchronize `audio_ws` (allowed values 2–3).

- `clk`  input  1  system clock; the same clock that drives `speaker_control`.
- `rst`  input  1  asynchronous, active-low reset.
- `audio_ws`  input  1  word-select line from `speaker_control`; a falling edge marks the start of a frame.
- `mute`  input  1  when high at a frame tick, the block outputs silence and consumes nothing.
- `src0_valid`  input  1  music source has a sample available.
- `src0_left`, `src0_right`  input  16 each  music sample, two's complement.
- `src1_valid`  input  1  alert source has a sample available.
- `src1_left`, `src1_right`  input  16 each  alert sample, two's complement.
- `src0_ready`  output  1  one-cycle pulse; the src0 sample is consumed on this clock edge.
- `src1_ready`  output  1  one-cycle pulse; the src1 sample is consumed on this clock edge.
- `audio_out_left`, `audio_out_right`  output  16 each  sample sent to `speaker_control`; held stable for a whole frame.
- `grant`  output  2  current state encoding: 00 = IDLE, 01 = PLAY0, 10 = PLAY1, 11 = MIX.
- `underflow_cnt`  output  8  saturating count of frames lost to underflow.

## Operation

- `audio_ws` passes through `SYNC_STAGES` flip-flops and then a falling-edge detector. The detector produces `frame_tick`, which is high for exactly one cycle per frame.
- The state machine (IDLE, PLAY0, PLAY1, MIX) changes state only in a `frame_tick` cycle. Between ticks, all outputs hold their values.
- Decision at each tick, evaluated in this order:
  1. `mute` = 1: go to IDLE. No ready pulse. Output 0/0.
  2. `src1_valid` = 1 and `src0_valid` = 1 with mixing compiled in: go to MIX. Pulse both readies. Output the saturated sum.
  3. `src1_valid` = 1: go to PLAY1. Pulse `src1_ready`. Output the src1 sample.
  4. `src0_valid` = 1: go to PLAY0. Pulse `src0_ready`. Output the src0 sample.
  5. Neither source valid: go to IDLE. Output 0/0. If the previous state was not IDLE, increment `underflow_cnt`.
- Source 1 always has strict priority. A src0 sample that is not consumed stays pending: the source keeps `valid` high and holds its data unchanged.
- A valid that is deasserted between ticks is ignored. Only the value at the tick matters.
- `underflow_cnt` saturates at 255 and does not wrap. Only reset clears it.

## Timing

- The `audio_ws` falling edge is seen on pin 1 and produces `frame_tick` high `SYNC_STAGES + 1` cycles later (3 cycles at the default).
- `srcN_ready` is driven combinationally from the registered `frame_tick`, the valids and `mute`, and is high only during the tick cycle. The source data is captured on the rising edge that ends that cycle.
- `audio_out_*`, `grant` and `underflow_cnt` change on the clock edge that ends the tick cycle, so they are valid 1 cycle after the tick. They are stable for the rest of the frame. `speaker_control` latches them well before its next frame.
- Reset values: `audio_out_left` = `audio_out_right` = 0, `grant` = 00 (IDLE), `underflow_cnt` = 0, both readies = 0, synchronizer flip-flops = 1 (so no false edge after reset).
- Reset mid-frame returns the block to IDLE immediately; a pending source sample is not consumed. The first tick after reset release requires a real `audio_ws` falling edge.
- If `audio_ws` is held constant, no ticks occur and the outputs are frozen.

## Configuration

- `AUDIO_ARB_MIX_EN`:
  - **Defined:** when both sources are valid at a tick, enter MIX. Each channel output is `src0 + src1` computed at 17 bits, then saturated to the range [-32768, 32767]. Both readies pulse in the same cycle.
  - **Undefined:** the MIX state and its adder are not generated, `grant` never reads 11, and both-valid resolves to PLAY1 under strict priority.

## Test plan

- Reset with `audio_ws` toggling, no sources valid: outputs 0/0, `grant` = 00, `underflow_cnt` = 0, no ready pulses.
- src0 valid with L = 0x1234, R = 0xEDCB: `src0_ready` pulses exactly 3 cycles after the ws fall, and the outputs show 0x1234/0xEDCB one cycle later with `grant` = 01.
- src0 and src1 both valid, src1 L = R = 0x7000, mixing undefined: PLAY1, only `src1_ready` pulses, and src0 stays pending. Drop src1: the next tick gives PLAY0.
- Same stimulus with `AUDIO_ARB_MIX_EN` defined and src0 L = 0x2000: `grant` = 11 and left output = 0x7FFF (saturated). With src0 = 0x8000 and src1 = 0x8000 (both negative full-scale), output = 0x8000 (negative saturation).
- Let the granted source run dry for 300 frames from PLAY0 and then recover: `underflow_cnt` increments once (IDLE→IDLE frames are not counted). Repeat the run-dry/recover pattern 300 times: `underflow_cnt` saturates at 255.
- Raise `mute` while in PLAY1, then assert `rst` = 0 mid-frame: the mute tick gives IDLE with output 0/0 and no ready pulse. The reset forces all outputs to their reset values asynchronously, with no clock edge needed.

Source files
------------

// File: rtl/audio_source_arbiter.sv
// Frame-synchronous arbiter between a music source (0) and an alert source (1) feeding speaker_control.
// Optional AUDIO_ARB_MIX_EN: both-valid frames enter MIX and output the saturated per-channel sum.
//
// state | meaning
// IDLE  | silence; nothing consumed this frame (mute, underflow, or after reset)
// PLAY0 | music sample from src0 presented for this frame
// PLAY1 | alert sample from src1 presented for this frame
// MIX   | saturated src0+src1 presented for this frame (AUDIO_ARB_MIX_EN only)
module audio_source_arbiter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        audio_ws,
    input  logic        mute,
    input  logic        src0_valid,
    input  logic [15:0] src0_left,
    input  logic [15:0] src0_right,
    input  logic        src1_valid,
    input  logic [15:0] src1_left,
    input  logic [15:0] src1_right,
    output logic        src0_ready,
    output logic        src1_ready,
    output logic [15:0] audio_out_left,
    output logic [15:0] audio_out_right,
    output logic [1:0]  grant,
    output logic [7:0]  underflow_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY0 = 2'b01,
        PLAY1 = 2'b10,
        MIX   = 2'b11
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic                   ws_prev;
    logic                   frame_tick;
    logic [15:0]            left_nxt, right_nxt;
    logic [7:0]             uf_nxt;

    // Synchronizer resets high so reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ws_sync    <= '1;
            ws_prev    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            ws_sync    <= {ws_sync[SYNC_STAGES-2:0], audio_ws};
            ws_prev    <= ws_sync[SYNC_STAGES-1];
            frame_tick <= ws_prev & ~ws_sync[SYNC_STAGES-1];
        end
    end

`ifdef AUDIO_ARB_MIX_EN
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        if (sum[16] != sum[15]) begin
            return sum[16] ? 16'h8000 : 16'h7FFF;
        end
        return sum[15:0];
    endfunction
`endif

    always_comb begin
        state_nxt  = state;
        left_nxt   = audio_out_left;
        right_nxt  = audio_out_right;
        uf_nxt     = underflow_cnt;
        src0_ready = 1'b0;
        src1_ready = 1'b0;
        if (frame_tick) begin
            if (mute) begin
                state_nxt = IDLE;
                left_nxt  = 16'h0000;
                right_nxt = 16'h0000;
            end
`ifdef AUDIO_ARB_MIX_EN
            else if (src1_valid && src0_valid) begin
                state_nxt  = MIX;
                src0_ready = 1'b1;
                src1_ready = 1'b1;
                left_nxt   = sat_add(src0_left, src1_left);
                right_nxt  = sat_add(src0_right, src1_right);
            end
`endif
            else if (src1_valid) begin
                state_nxt  = PLAY1;
                src1_ready = 1'b1;
                left_nxt   = src1_left;
                right_nxt  = src1_right;
            end else if (src0_valid) begin
                state_nxt  = PLAY0;
                src0_ready = 1'b1;
                left_nxt   = src0_left;
                right_nxt  = src0_right;
            end else begin
                state_nxt = IDLE;
                left_nxt  = 16'h0000;
                right_nxt = 16'h0000;
                // Only a frame that had audio and lost it counts; silent stretches do not.
                if (state != IDLE && underflow_cnt != 8'hFF) begin
                    uf_nxt = underflow_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            audio_out_left  <= 16'h0000;
            audio_out_right <= 16'h0000;
            underflow_cnt   <= 8'h00;
        end else begin
            state           <= state_nxt;
            audio_out_left  <= left_nxt;
            audio_out_right <= right_nxt;
            underflow_cnt   <= uf_nxt;
        end
    end

    assign grant = state;

endmodule
